// File: rtl/wptr_full_gen_pkg.sv
// wptr_full_gen_pkg: shared async-FIFO pointer constants and Gray conversion helpers
package wptr_full_gen_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_PTR_W = DEF_ADDR_WIDTH + 1;
  localparam int MAX_W = 16;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/wptr_full_gen_if.sv
// wptr_full_gen_if: write-pointer in, full/level/Gray pointer out
interface wptr_full_gen_if import wptr_full_gen_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic [ADDR_WIDTH:0] w_ptr;
  logic [ADDR_WIDTH:0] r_ptr_gray;
  logic [ADDR_WIDTH:0] w_level;
  logic [ADDR_WIDTH:0] w_ptr_gray;
  logic full_flag;
  logic almost_full;
  modport master (output w_ptr, r_ptr_gray, input full_flag, almost_full, w_level, w_ptr_gray);
  modport slave (input w_ptr, r_ptr_gray, output full_flag, almost_full, w_level, w_ptr_gray);
endinterface

// File: rtl/wptr_full_gen_ptr_sync.sv
// ptr_sync: multi-flop synchroniser chain for a Gray pointer crossing clock domains
module ptr_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_chain;
  // plain shift chain, nothing between stages
  always_ff @(posedge clk)
    if (rst) r_chain <= '0;
    else r_chain <= {r_chain[STAGES-2:0], i_d};
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/wptr_full_gen.sv
// wptr_full_gen: write-domain Gray pointer, synchronised read pointer, full/almost_full/level
module wptr_full_gen import wptr_full_gen_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_LVL = 14,
  parameter int SYNC_STAGES = 2
) (
  input logic w_clk,
  input logic rst,
  wptr_full_gen_if.slave bus
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  if (SYNC_STAGES < 2 || ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > (1 << ADDR_WIDTH)) begin : g_bad_param
    $fatal(1, "wptr_full_gen: illegal SYNC_STAGES or ALMOST_FULL_LVL");
  end
  logic [PTR_W-1:0] w_ptr_next, w_gray_next, w_rptr_sync, w_rptr_bin, w_level_next;
  logic w_full_next;
  ptr_sync #(.STAGES(SYNC_STAGES), .WIDTH(PTR_W)) u_sync (
    .clk(w_clk),
    .rst(rst),
    .i_d(bus.r_ptr_gray),
    .o_q(w_rptr_sync)
  );
  // predict the counter's next value so flags land on the same edge as the pointer
  assign w_ptr_next = bus.full_flag ? bus.w_ptr : bus.w_ptr + 1'b1;
  assign w_gray_next = PTR_W'(bin2gray(MAX_W'(w_ptr_next)));
  assign w_rptr_bin = PTR_W'(gray2bin(MAX_W'(w_rptr_sync)));
  assign w_full_next = w_gray_next == {~w_rptr_sync[PTR_W-1 -: 2], w_rptr_sync[PTR_W-3:0]};
  assign w_level_next = w_ptr_next - w_rptr_bin;
  // register Gray pointer and flags from the predicted pointer
  always_ff @(posedge w_clk)
    if (rst) begin
      bus.w_ptr_gray <= '0;
      bus.full_flag <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.w_level <= '0;
    end else begin
      bus.w_ptr_gray <= w_gray_next;
      bus.full_flag <= w_full_next;
      bus.almost_full <= w_level_next >= PTR_W'(ALMOST_FULL_LVL);
      bus.w_level <= w_level_next;
    end
endmodule

// File: doc/wptr_full_gen.md
Name: wptr_full_gen

Overview:
Write-domain pointer/flag stage of the asynchronous FIFO. It sits directly downstream of the write pointer counter and consumes its binary pointer. It converts the pointer to Gray code for crossing into the read domain, and synchronises the read-domain Gray pointer into w_clk. It produces the registered full_flag that feeds back into the write pointer counter, plus almost_full and a fill level.

Parameters:
ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH (16); all pointers are ADDR_WIDTH+1 bits (5)
ALMOST_FULL_LVL, 14, almost_full asserts when level >= this value; legal range 1..2**ADDR_WIDTH
SYNC_STAGES, 2, flop stages on the r_ptr_gray crossing; minimum 2

Ports:
w_clk  in  1  write-domain clock; all state is on its rising edge
rst  in  1  reset; synchronous, active-high
w_ptr  in  ADDR_WIDTH+1  binary write pointer from the write pointer counter
r_ptr_gray  in  ADDR_WIDTH+1  Gray read pointer, launched from read-clock flops (asynchronous to w_clk)
full_flag  out  1  registered FIFO-full; returned to the write pointer counter as its stall
almost_full  out  1  registered, level >= ALMOST_FULL_LVL
w_level  out  ADDR_WIDTH+1  registered fill level as seen in the write domain, 0..2**ADDR_WIDTH
w_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, for the read-domain synchroniser

Behaviour:
- Reset (rst=1 at a w_clk edge):
  - All sync flops cleared to 0.
  - full_flag=0, almost_full=0, w_level=0, w_ptr_gray=0.
  - rst has priority over every other input.
- Next-pointer model (combinational): w_ptr_next = full_flag ? w_ptr : w_ptr+1, modulo 2**(ADDR_WIDTH+1). This mirrors the counter's increment rule, so w_ptr_next is the value w_ptr takes next cycle.
- Gray encode: gray(x) = x ^ (x>>1). Register w_ptr_gray <= gray(w_ptr_next). After reset, w_ptr_gray == gray(w_ptr) every cycle, with no extra lag.
- Synchroniser:
  - SYNC_STAGES-deep shift chain on r_ptr_gray; rptr_sync is the last stage.
  - A change on r_ptr_gray is visible in rptr_sync after SYNC_STAGES edges.
  - No logic is allowed between the sync flops.
- Gray decode (combinational): rptr_bin[MSB] = rptr_sync[MSB]; rptr_bin[i] = rptr_bin[i+1] ^ rptr_sync[i].
- Full:
  - full_flag <= (gray(w_ptr_next) == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}), i.e. top two bits inverted, rest equal.
  - Equivalently, level_next == 2**ADDR_WIDTH.
  - Asserts in the same edge that takes w_ptr to read+depth. The counter therefore never overruns.
- Level:
  - level_next = (w_ptr_next - rptr_bin) mod 2**(ADDR_WIDTH+1).
  - w_level <= level_next; almost_full <= (level_next >= ALMOST_FULL_LVL).
- Latency:
  - A write step is reflected in w_level/flags on the same edge that updates w_ptr.
  - A read step takes SYNC_STAGES+1 w_clk edges from the r_ptr_gray change until full/level release. Release is pessimistic and never optimistic.
- Wrap-around: pointer arithmetic wraps at 2**(ADDR_WIDTH+1) (31 -> 0). Full/level stay correct across the wrap because of the extra MSB.
- Simultaneous write step and read step in the same cycle: the level is unchanged and full_flag holds its computed value; no glitch is permitted.
- Reset mid-operation: outputs return to reset values on the next edge. The sync chain re-fills from live r_ptr_gray within SYNC_STAGES edges. Both domains are reset together at system level.
- Static check: fatal error if SYNC_STAGES < 2 or ALMOST_FULL_LVL is outside 1..2**ADDR_WIDTH.

Decomposition:
- Shared FIFO package:
  - ADDR_WIDTH default and PTR_W = ADDR_WIDTH+1.
  - bin2gray and gray2bin functions, shared with the read-side empty generator.
- One sub-module, ptr_sync: a parameterised SYNC_STAGES x width flop chain with synchronous active-high reset. The read side reuses it.

Test Plan:
1. rst=1 for 3 edges, then r_ptr_gray=0 held; the counter model starts from w_ptr=0 → after 16 increment edges: w_ptr=16, w_ptr_gray=5'b11000, w_level=16, full_flag=1; almost_full rose when w_level reached 14; the counter stalls at 16.
2. From full, step r_ptr_gray 0 → 5'b00001 (read ptr 1) → full_flag stays 1 for exactly 2 edges, falls on the 3rd, with w_level=15. One more write re-asserts full with w_ptr=17.
3. Wrap: preload both pointers to 28 (r_ptr_gray=5'b10010), then 10 writes → w_ptr goes 29..31,0..6; w_level=10; full_flag=0; w_ptr_gray matches gray(w_ptr) every cycle.
4. Simultaneous: level 15, write step and read step landing on the same edge → w_level stays 15, full_flag stays 0, no one-cycle pulse.
5. Reset mid-operation at level 12 → next edge: w_level=0, flags 0, w_ptr_gray=0. With r_ptr_gray held at 0, no spurious full appears while the sync chain refills.
6. Parameters ADDR_WIDTH=3, SYNC_STAGES=3, ALMOST_FULL_LVL=6 → full at level 8; almost_full at 6; read release latency is 4 edges.
